// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } frame_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Address width for a buffer of 'depth' entries, never less than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_rx_buf.sv
// Payload store for one frame: synchronous write, asynchronous read.
module frame_buf
    import uart_frame_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic          sysclk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [N-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [N-1:0]  rdata_o
);

    logic [N-1:0] mem_q [DEPTH];

    // NOTE: the storage has no reset; the parser's pointers decide which
    // entries are meaningful, so stale contents are never observed.
    // NOTE: sequential state is always assigned with non-blocking '<='.
    always_ff @(posedge sysclk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind the UART receiver: SOF, LEN, payload, CSUM; releases
// checksum-clean payloads as a valid/ready stream with a last marker.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int           N       = 8,
    parameter int           MAX_LEN = 16,
    parameter int           TIMEOUT = 1000,
    parameter logic [N-1:0] SOF     = N'(SOF_DEFAULT)
) (
    input  logic         sysclk,
    input  logic         reset_n,
    input  logic [N-1:0] rx_data_i,
    input  logic         rx_valid_i,
    output logic [N-1:0] data_o,
    output logic         valid_o,
    output logic         last_o,
    input  logic         ready_i,
    output logic         frame_ok_o,
    output logic         csum_err_o,
    output logic         len_err_o,
    output logic         timeout_o,
    output logic         overrun_o
);

    localparam int AW = ptr_width(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    frame_state_t  state_q;
    logic [N-1:0]  len_q;
    logic [N-1:0]  cnt_q;
    logic [N-1:0]  acc_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [TW-1:0] tmo_q;
    logic [N-1:0]  data_q;
    logic          valid_q;
    logic          last_q;
    logic          frame_ok_q;
    logic          csum_err_q;
    logic          len_err_q;
    logic          timeout_q;
    logic          overrun_q;

    logic          buf_we;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  buf_rdata;
    logic [N-1:0]  sum;
    logic [N-1:0]  rd_next_ext;
    logic          tmo_hit;
    logic          handshake;

    assign sum         = acc_q + rx_data_i;
    assign rd_next_ext = N'(rd_ptr_q) + N'(1);
    assign tmo_hit     = (tmo_q == TW'(TIMEOUT));
    assign handshake   = valid_q && ready_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        buf_we  = 1'b0;
        rd_addr = '0;
        if (state_q == PAYLOAD && rx_valid_i) begin
            buf_we = 1'b1;
        end
        // The read port pre-fetches the byte that follows the one on data_o.
        if (state_q == DRAIN) begin
            rd_addr = rd_ptr_q + 1'b1;
        end
    end

    frame_buf #(
        .N     (N),
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .sysclk  (sysclk),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (rx_data_i),
        .raddr_i (rd_addr),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tmo_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            frame_ok_q <= 1'b0;
            csum_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            frame_ok_q <= 1'b0;
            csum_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;

            if (state_q == IDLE || state_q == DRAIN || rx_valid_i) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (rx_valid_i && rx_data_i == SOF) begin
                        state_q <= LEN;
                    end
                end

                LEN: begin
                    if (rx_valid_i) begin
                        acc_q    <= rx_data_i;
                        len_q    <= rx_data_i;
                        cnt_q    <= rx_data_i;
                        wr_ptr_q <= '0;
                        if (rx_data_i == '0) begin
                            state_q <= CSUM;
                        end else if (rx_data_i > N'(MAX_LEN)) begin
                            len_err_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= PAYLOAD;
                        end
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end

                PAYLOAD: begin
                    if (rx_valid_i) begin
                        acc_q    <= sum;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        cnt_q    <= cnt_q - 1'b1;
                        if (cnt_q == N'(1)) begin
                            state_q <= CSUM;
                        end
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end

                CSUM: begin
                    if (rx_valid_i) begin
                        if (sum == '0) begin
                            frame_ok_q <= 1'b1;
                            if (len_q == '0) begin
                                state_q <= IDLE;
                            end else begin
                                state_q  <= DRAIN;
                                rd_ptr_q <= '0;
                                data_q   <= buf_rdata;
                                valid_q  <= 1'b1;
                                last_q   <= (len_q == N'(1));
                            end
                        end else begin
                            csum_err_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end

                DRAIN: begin
                    // No backpressure upstream: bytes arriving now are lost.
                    if (rx_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (handshake) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                            data_q   <= buf_rdata;
                            last_q   <= (rd_next_ext == len_q - N'(1));
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign frame_ok_o = frame_ok_q;
    assign csum_err_o = csum_err_q;
    assign len_err_o  = len_err_q;
    assign timeout_o  = timeout_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with an output scoreboard and pulse monitor.
module tb_uart_frame_rx;

    localparam int TIMEOUT = 1000;

    logic       sysclk   = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ready    = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       last_o;
    logic       frame_ok_o;
    logic       csum_err_o;
    logic       len_err_o;
    logic       timeout_o;
    logic       overrun_o;

    int checks     = 0;
    int errors     = 0;
    int n_ok       = 0;
    int n_csum     = 0;
    int n_len      = 0;
    int n_tmo      = 0;
    int n_ovr      = 0;
    int violations = 0;

    logic [8:0] sb [$];

    uart_frame_rx #(
        .N       (8),
        .MAX_LEN (16),
        .TIMEOUT (TIMEOUT),
        .SOF     (8'hA5)
    ) dut (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .ready_i    (ready),
        .frame_ok_o (frame_ok_o),
        .csum_err_o (csum_err_o),
        .len_err_o  (len_err_o),
        .timeout_o  (timeout_o),
        .overrun_o  (overrun_o)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge sysclk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge sysclk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic last);
        sb.push_back({last, b});
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge sysclk);
            #1;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic check_counts(input string tag, input int ok, input int cs, input int ln,
                                input int tm, input int ov);
        repeat (2) @(posedge sysclk);
        #1;
        check(tag, {8'(n_ok), 8'(n_csum), 8'(n_len), 8'(n_tmo), 8'(n_ovr)},
              {8'(ok), 8'(cs), 8'(ln), 8'(tm), 8'(ov)});
    endtask

    // Counts status pulses, checks pulse shape, hold stability and output order.
    task automatic monitor();
        logic [8:0] held;
        logic [8:0] exp;
        logic       holding;
        logic [3:0] prev;
        logic [3:0] cur;
        holding = 1'b0;
        prev    = 4'b0;
        held    = '0;
        forever begin
            @(negedge sysclk);
            if (!reset_n) begin
                holding = 1'b0;
                prev    = 4'b0;
            end else begin
                cur = {frame_ok_o, csum_err_o, len_err_o, timeout_o};
                if (frame_ok_o) n_ok++;
                if (csum_err_o) n_csum++;
                if (len_err_o)  n_len++;
                if (timeout_o)  n_tmo++;
                if (overrun_o)  n_ovr++;
                if ($countones(cur) > 1) violations++;
                if ((cur & prev) != 4'b0) violations++;
                prev = cur;
                if (valid_o && holding) begin
                    check("hold_stable", {last_o, data_o}, held);
                end
                if (valid_o && ready) begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_output observed=%0h expected=none", {last_o, data_o});
                    end
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        check("out_byte", {last_o, data_o}, exp);
                    end
                    holding = 1'b0;
                end else if (valid_o) begin
                    holding = 1'b1;
                    held    = {last_o, data_o};
                end else begin
                    holding = 1'b0;
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge sysclk);
        #1;
        check("reset_outputs",
              {data_o, valid_o, last_o, frame_ok_o, csum_err_o, len_err_o, timeout_o, overrun_o}, 0);
        reset_n = 1'b1;

        // Good frame: first byte and pulse appear the cycle after CSUM
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b0); expect_byte(8'h33, 1'b1);
        send(8'h97);
        check("good_first_cycle", {frame_ok_o, valid_o, last_o, data_o}, {1'b1, 1'b1, 1'b0, 8'h11});
        wait_drain("good_drain");
        check_counts("good_counts", 1, 0, 0, 0, 0);

        // Bad checksum: error pulse, nothing released
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
        check("bad_csum_cycle", {csum_err_o, frame_ok_o, valid_o}, 3'b100);
        check_counts("bad_counts", 1, 1, 0, 0, 0);

        // Oversize length, then an empty frame
        send(8'hA5); send(8'h11);
        check("len_err_cycle", {len_err_o, valid_o}, 2'b10);
        send(8'hA5); send(8'h00); send(8'h00);
        check("empty_frame", {frame_ok_o, valid_o}, 2'b10);
        check_counts("len_counts", 2, 1, 1, 0, 0);

        // Truncation: timeout fires exactly TIMEOUT+1 cycles after the last byte
        send(8'hA5); send(8'h02); send(8'h44);
        repeat (TIMEOUT) @(posedge sysclk);
        #1;
        check("timeout_not_yet", timeout_o, 1'b0);
        @(posedge sysclk);
        #1;
        check("timeout_pulse", timeout_o, 1'b1);
        send(8'hA5); send(8'h02); send(8'h01); send(8'hFF);
        expect_byte(8'h01, 1'b0); expect_byte(8'hFF, 1'b1);
        send(8'hFE);
        wait_drain("after_timeout_drain");
        check_counts("timeout_counts", 3, 1, 1, 1, 0);

        // Byte arriving on the timeout cycle wins; SOF value used as CSUM data
        send(8'hA5);
        repeat (TIMEOUT - 1) @(posedge sysclk);
        send(8'h01); send(8'h5A);
        expect_byte(8'h5A, 1'b1);
        send(8'hA5);
        wait_drain("byte_wins_drain");
        check_counts("byte_wins_counts", 4, 1, 1, 1, 0);

        // Backpressure and overrun during DRAIN
        ready = 1'b0;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b0); expect_byte(8'h33, 1'b1);
        send(8'h97);
        send(8'hA5);
        check("overrun_pulse_1", overrun_o, 1'b1);
        send(8'h00);
        check("overrun_pulse_2", overrun_o, 1'b1);
        check("stall_hold", {valid_o, last_o, data_o}, {1'b1, 1'b0, 8'h11});
        ready = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        check("last_handshake", {valid_o, last_o, data_o}, {1'b1, 1'b1, 8'h33});
        // SOF strobed in the cycle right after the final handshake
        send(8'hA5); send(8'h01); send(8'h10);
        expect_byte(8'h10, 1'b1);
        send(8'hEF);
        wait_drain("overrun_drain");
        check_counts("overrun_counts", 6, 1, 1, 1, 2);

        // Reset mid-payload aborts silently
        send(8'hA5); send(8'h03); send(8'h11);
        @(posedge sysclk);
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              {data_o, valid_o, last_o, frame_ok_o, csum_err_o, len_err_o, timeout_o, overrun_o}, 0);
        repeat (2) @(posedge sysclk);
        #1;
        reset_n = 1'b1;
        send(8'hA5); send(8'h01); send(8'h7E);
        expect_byte(8'h7E, 1'b1);
        send(8'h81);
        check("after_reset_first", {frame_ok_o, valid_o, last_o, data_o}, {1'b1, 1'b1, 1'b1, 8'h7E});
        wait_drain("after_reset_drain");
        check_counts("reset_counts", 7, 1, 1, 1, 2);

        check("scoreboard_empty", sb.size(), 0);
        check("pulse_shape", violations, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
